gshare_spec: RTL

Parametrised two-way gshare branch predictor for the superscalar front end. It adds speculative global history, updated at predict time, and history repair on mispredict. Counter updates are indexed with the history snapshot captured at prediction. A hardware sweep initialises the table after reset. The fetch stage reads two slots per cycle; the branch resolution unit returns one update per cycle.

---
 rtl/gshare_spec_if.sv | 33 +++
 rtl/gshare_spec.sv | 106 ++++++++++
 2 files changed

// File: rtl/gshare_spec_if.sv
// Predict/update bundle between the fetch front end, the branch resolution unit
// and the gshare predictor. The predictor sits on the slave side.
interface gshare_spec_if #(
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned HIST_W = 8
) ();
   logic              ready;
   logic              pred_valid1;
   logic              pred_valid2;
   logic [IDX_W-1:0]  raddr1;
   logic [IDX_W-1:0]  raddr2;
   logic              pred1;
   logic              pred2;
   logic [HIST_W-1:0] hist1;
   logic [HIST_W-1:0] hist2;
   logic              upd_valid;
   logic [IDX_W-1:0]  upd_addr;
   logic [HIST_W-1:0] upd_hist;
   logic              upd_taken;
   logic              upd_mispred;

   modport master (
      input  ready, pred1, pred2, hist1, hist2,
      output pred_valid1, pred_valid2, raddr1, raddr2,
             upd_valid, upd_addr, upd_hist, upd_taken, upd_mispred
   );

   modport slave (
      output ready, pred1, pred2, hist1, hist2,
      input  pred_valid1, pred_valid2, raddr1, raddr2,
             upd_valid, upd_addr, upd_hist, upd_taken, upd_mispred
   );
endinterface

// File: rtl/gshare_spec.sv
// Two-slot gshare predictor: speculative global history updated at predict time,
// repaired from the branch's own snapshot on mispredict; table swept after reset.
module gshare_spec #(
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned HIST_W = 8,
   parameter int unsigned CNT_W  = 2
) (
   input  logic        clk,
   input  logic        rst,
   gshare_spec_if.slave bp
);
   localparam int unsigned    DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] WNT = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  init_cnt_q;
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic              ready_q;
   logic [CNT_W-1:0]  pht_q [DEPTH];

   logic              run;
   logic              p1, p2;
   logic [HIST_W-1:0] h2;
   logic [IDX_W-1:0]  idx1, idx2, uidx;
   logic [CNT_W-1:0]  ucnt, ucnt_d;

   // Index hash: history is zero-extended, so high address bits pass through.
   function automatic logic [IDX_W-1:0] hash(input logic [IDX_W-1:0] a,
                                              input logic [HIST_W-1:0] h);
      logic [IDX_W-1:0] z;
      z = '0;
      z[HIST_W-1:0] = h;
      return a ^ z;
   endfunction

   // Newest outcome enters the MSB; also correct for HIST_W == 1.
   function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h,
                                                   input logic b);
      logic [HIST_W-1:0] r;
      r = h >> 1;
      r[HIST_W-1] = b;
      return r;
   endfunction

   always_comb begin
      run  = (state_q == S_RUN);
      idx1 = hash(bp.raddr1, ghr_q);
      p1   = run & pht_q[idx1][CNT_W-1];
      h2   = shift_in(ghr_q, p1);
      idx2 = hash(bp.raddr2, h2);
      p2   = run & pht_q[idx2][CNT_W-1];

      uidx = hash(bp.upd_addr, bp.upd_hist);
      ucnt = pht_q[uidx];
      if (bp.upd_taken) ucnt_d = (ucnt == CMAX) ? ucnt : ucnt + CNT_W'(1);
      else              ucnt_d = (ucnt == '0)   ? ucnt : ucnt - CNT_W'(1);

      // Repair wins over any same-cycle speculative shift.
      ghr_d = ghr_q;
      if (bp.upd_valid && bp.upd_mispred)
         ghr_d = shift_in(bp.upd_hist, bp.upd_taken);
      else if (bp.pred_valid1 && bp.pred_valid2)
         ghr_d = shift_in(shift_in(ghr_q, p1), p2);
      else if (bp.pred_valid1)
         ghr_d = shift_in(ghr_q, p1);
   end

   assign bp.ready = ready_q;
   assign bp.pred1 = p1;
   assign bp.pred2 = p2;
   assign bp.hist1 = ghr_q;
   assign bp.hist2 = h2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         ghr_q      <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               init_cnt_q <= init_cnt_q + IDX_W'(1);
               if (init_cnt_q == '1) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: ghr_q <= ghr_d;
            default: state_q <= S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_INIT)
            pht_q[init_cnt_q] <= WNT;
         else if (bp.upd_valid)
            pht_q[uidx] <= ucnt_d;
      end
   end
endmodule
